// File: rtl/expr_token_writer.sv
// Expression entry buffer: accepts keypad tokens, enforces digit/operator syntax,
// supports backspace/clear, and terminates with '#' on enter.
module expr_token_writer #(
  parameter int DEPTH = 100,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [7:0]    key_code,
  output logic          key_ready,
  input  logic          key_back,
  input  logic          key_clear,
  input  logic [AW-1:0] rd_index,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] length,
  output logic          done,
  output logic          err
);

  // Handshake: a token is consumed on a rising edge where key_valid && key_ready;
  // key_ready depends only on state, never on key_valid.

  typedef enum logic {
    ST_EDIT = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_DIGIT = 2'd1,
    CLS_OP    = 2'd2
  } cls_t;

  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
  localparam logic [7:0]    TERM      = 8'd10;

  logic [7:0]    mem [DEPTH];

  state_t        state, state_n;
  cls_t          last_cls, cls_n;
  logic [AW-1:0] wr_ptr, ptr_n;
  logic          err_n;
  logic          we;
  logic [AW-1:0] back_idx;
  logic [7:0]    back_tok;
  logic          is_digit, is_op, is_term;

  assign is_digit = (key_code <= 8'd9);
  assign is_op    = (key_code >= 8'd20) && (key_code <= 8'd23);
  assign is_term  = (key_code == TERM);

  // Token that becomes the new tail after a backspace; only consulted when wr_ptr >= 2.
  assign back_idx = wr_ptr - AW'(2);
  assign back_tok = mem[back_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EDIT;
      wr_ptr   <= '0;
      last_cls <= CLS_NONE;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      wr_ptr   <= ptr_n;
      last_cls <= cls_n;
      err      <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= key_code;
  end

  always_comb begin
    state_n   = state;
    ptr_n     = wr_ptr;
    cls_n     = last_cls;
    err_n     = err;
    we        = 1'b0;
    key_ready = (state == ST_EDIT);
    done      = (state == ST_DONE);

    if (key_clear) begin
      state_n = ST_EDIT;
      ptr_n   = '0;
      cls_n   = CLS_NONE;
      err_n   = 1'b0;
    end else if (key_back) begin
      if (state == ST_EDIT && wr_ptr != '0) begin
        ptr_n = wr_ptr - AW'(1);
        if (wr_ptr == AW'(1))
          cls_n = CLS_NONE;
        else if (back_tok >= 8'd20)
          cls_n = CLS_OP;
        else
          cls_n = CLS_DIGIT;
      end
    end else if (key_valid && key_ready) begin
      if (is_digit) begin
        if (wr_ptr < LAST_SLOT) begin
          we    = 1'b1;
          ptr_n = wr_ptr + AW'(1);
          cls_n = CLS_DIGIT;
        end else begin
          err_n = 1'b1;
        end
      end else if (is_op) begin
        if (last_cls != CLS_DIGIT || wr_ptr >= LAST_SLOT) begin
          err_n = 1'b1;
        end else begin
          we    = 1'b1;
          ptr_n = wr_ptr + AW'(1);
          cls_n = CLS_OP;
        end
      end else if (is_term) begin
        // '#' lands in the slot after the last token without advancing the pointer.
        if (last_cls == CLS_DIGIT) begin
          we      = 1'b1;
          state_n = ST_DONE;
        end else begin
          err_n = 1'b1;
        end
      end else begin
        err_n = 1'b1;
      end
    end
  end

  // Anything beyond the stored expression reads as a terminator.
  always_comb begin
    rd_data = TERM;
    if (int'(rd_index) < DEPTH &&
        (rd_index < wr_ptr || (rd_index == wr_ptr && state == ST_DONE)))
      rd_data = mem[rd_index];
  end

  assign length = wr_ptr;

endmodule

// File: tb/tb_expr_token_writer.sv
// Self-checking bench for expr_token_writer: vector table plus hand-written
// sequences for buffer fill and asynchronous reset.
module tb_expr_token_writer;

  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam int W     = AW + 3;

  localparam int OP_KEY     = 0;
  localparam int OP_BACK    = 1;
  localparam int OP_CLR     = 2;
  localparam int OP_CLRKEY  = 3;
  localparam int OP_READ    = 4;
  localparam int OP_BACKKEY = 5;

  typedef struct {
    int         op;
    logic [7:0] arg;
    int         exp_len;
    logic       exp_err;
    logic       exp_done;
    logic [7:0] exp_rd;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_ready;
  logic          key_back;
  logic          key_clear;
  logic [AW-1:0] rd_index;
  logic [7:0]    rd_data;
  logic [AW-1:0] length;
  logic          done;
  logic          err;

  logic [W-1:0]  exp_q[$];
  vec_t          vecs[$];
  logic [7:0]    fill_codes[DEPTH];
  int            checks;
  int            errors;

  expr_token_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_back  (key_back),
    .key_clear (key_clear),
    .rd_index  (rd_index),
    .rd_data   (rd_data),
    .length    (length),
    .done      (done),
    .err       (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(int op, logic [7:0] arg, int len, logic e, logic d,
                              logic [7:0] rd);
    vec_t v;
    v.op = op; v.arg = arg; v.exp_len = len; v.exp_err = e; v.exp_done = d; v.exp_rd = rd;
    vecs.push_back(v);
  endfunction

  function automatic logic [W-1:0] pack_exp(int len, logic e, logic d);
    return {AW'(len), e, d, ~d};
  endfunction

  // scoreboard: pop the oldest expectation and compare against the live outputs
  task automatic check_status(input string name);
    logic [W-1:0] exp;
    logic [W-1:0] got;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard queue empty", name);
    end else begin
      exp = exp_q.pop_front();
      got = {length, err, done, key_ready};
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got len=%0d err=%b done=%b ready=%b, want len=%0d err=%b done=%b ready=%b",
                 name, got[W-1:3], got[2], got[1], got[0], exp[W-1:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic check_rd(input string name, input int idx, input logic [7:0] exp);
    rd_index = AW'(idx);
    #1;
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("FAIL %s: rd_data[%0d] got %0d want %0d", name, idx, rd_data, exp);
    end
  endtask

  // driver: one command per cycle, inputs set on the falling edge
  task automatic drive(input string name, input int op, input logic [7:0] arg,
                       input int len, input logic e, input logic d);
    @(negedge clk);
    key_valid = (op == OP_KEY || op == OP_CLRKEY || op == OP_BACKKEY);
    key_back  = (op == OP_BACK || op == OP_BACKKEY);
    key_clear = (op == OP_CLR || op == OP_CLRKEY);
    key_code  = arg;
    exp_q.push_back(pack_exp(len, e, d));
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_back  = 1'b0;
    key_clear = 1'b0;
    check_status(name);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'd0;
    key_back  = 1'b0;
    key_clear = 1'b0;
    rd_index  = '0;

    // entry 1,5,*,1,0,# then commands while locked
    add(OP_KEY,     8'd1,  1, 0, 0, 0);
    add(OP_KEY,     8'd5,  2, 0, 0, 0);
    add(OP_KEY,     8'd22, 3, 0, 0, 0);
    add(OP_KEY,     8'd1,  4, 0, 0, 0);
    add(OP_KEY,     8'd0,  5, 0, 0, 0);
    add(OP_KEY,     8'd10, 5, 0, 1, 0);
    add(OP_READ,    8'd0,  0, 0, 0, 8'd1);
    add(OP_READ,    8'd1,  0, 0, 0, 8'd5);
    add(OP_READ,    8'd2,  0, 0, 0, 8'd22);
    add(OP_READ,    8'd3,  0, 0, 0, 8'd1);
    add(OP_READ,    8'd4,  0, 0, 0, 8'd0);
    add(OP_READ,    8'd5,  0, 0, 0, 8'd10);
    add(OP_READ,    8'd6,  0, 0, 0, 8'd10);
    add(OP_READ,    8'd120, 0, 0, 0, 8'd10);
    add(OP_KEY,     8'd4,  5, 0, 1, 0);
    add(OP_BACK,    8'd0,  5, 0, 1, 0);
    add(OP_READ,    8'd5,  0, 0, 0, 8'd10);
    add(OP_CLRKEY,  8'd4,  0, 0, 0, 0);
    add(OP_READ,    8'd0,  0, 0, 0, 8'd10);
    // unknown code, backspace on empty buffer
    add(OP_KEY,     8'd15, 0, 1, 0, 0);
    add(OP_CLR,     8'd0,  0, 0, 0, 0);
    add(OP_BACK,    8'd0,  0, 0, 0, 0);
    // leading operator
    add(OP_KEY,     8'd20, 0, 1, 0, 0);
    add(OP_KEY,     8'd3,  1, 1, 0, 0);
    add(OP_CLR,     8'd0,  0, 0, 0, 0);
    add(OP_READ,    8'd0,  0, 0, 0, 8'd10);
    // double operator, backspace restores DIGIT class, back beats key
    add(OP_KEY,     8'd7,  1, 0, 0, 0);
    add(OP_KEY,     8'd21, 2, 0, 0, 0);
    add(OP_KEY,     8'd22, 2, 1, 0, 0);
    add(OP_BACK,    8'd0,  1, 1, 0, 0);
    add(OP_KEY,     8'd22, 2, 1, 0, 0);
    add(OP_KEY,     8'd10, 2, 1, 0, 0);
    add(OP_BACKKEY, 8'd4,  1, 1, 0, 0);
    add(OP_KEY,     8'd4,  2, 1, 0, 0);
    add(OP_KEY,     8'd10, 2, 1, 1, 0);
    add(OP_READ,    8'd0,  0, 0, 0, 8'd7);
    add(OP_READ,    8'd1,  0, 0, 0, 8'd4);
    add(OP_READ,    8'd2,  0, 0, 0, 8'd10);
    add(OP_CLR,     8'd0,  0, 0, 0, 0);

    #12;
    exp_q.push_back(pack_exp(0, 0, 0));
    check_status("reset_state");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].op == OP_READ)
        check_rd($sformatf("vec%0d_rd", i), int'(vecs[i].arg), vecs[i].exp_rd);
      else
        drive($sformatf("vec%0d", i), vecs[i].op, vecs[i].arg,
              vecs[i].exp_len, vecs[i].exp_err, vecs[i].exp_done);
    end

    // fill every usable slot, then overflow, then terminate in the reserved slot
    for (int i = 0; i < DEPTH - 1; i++) begin
      fill_codes[i] = 8'($urandom_range(0, 9));
      drive($sformatf("fill%0d", i), OP_KEY, fill_codes[i], i + 1, 0, 0);
    end
    drive("overflow_digit", OP_KEY, 8'd5, DEPTH - 1, 1, 0);
    drive("overflow_op", OP_KEY, 8'd20, DEPTH - 1, 1, 0);
    drive("full_term", OP_KEY, 8'd10, DEPTH - 1, 1, 1);
    check_rd("full_rd99", DEPTH - 1, 8'd10);
    check_rd("full_rd98", DEPTH - 2, fill_codes[DEPTH - 2]);
    check_rd("full_rd50", 50, fill_codes[50]);
    check_rd("full_rd0", 0, fill_codes[0]);
    drive("full_clear", OP_CLR, 8'd0, 0, 0, 0);

    // asynchronous reset between edges, mid-entry with err set
    drive("pre_rst_a", OP_KEY, 8'd2, 1, 0, 0);
    drive("pre_rst_b", OP_KEY, 8'd3, 2, 0, 0);
    drive("pre_rst_c", OP_KEY, 8'd22, 3, 0, 0);
    drive("pre_rst_d", OP_KEY, 8'd23, 3, 1, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(pack_exp(0, 0, 0));
    check_status("async_reset");
    @(negedge clk);
    rst = 1'b1;
    drive("post_rst_a", OP_KEY, 8'd9, 1, 0, 0);
    drive("post_rst_b", OP_KEY, 8'd10, 1, 0, 1);
    check_rd("post_rst_rd0", 0, 8'd9);
    check_rd("post_rst_rd1", 1, 8'd10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_token_writer.md
Name: expr_token_writer

Overview:
- Expression entry buffer that builds the token stream consumed by the calculator evaluator.
- Accepts one key token per cycle from the keypad decoder and checks basic syntax.
- Supports backspace and clear, and appends the '#' terminator on enter.
- Exposes an index-addressed combinational read port, index in and token out, so the evaluator reads it the same way as the fixed expression store.

Parameters:
- DEPTH, 100, number of token slots. The last slot is reserved for '#'.
- AW, 7, index width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- key_valid  in  1  key_code is presented this cycle
- key_code  in  8  token: 0-9 digit, 10 '#'/enter, 20 '+', 21 '-', 22 '*', 23 '/'
- key_ready  out  1  buffer accepts a token this cycle
- key_back  in  1  backspace, single-cycle pulse
- key_clear  in  1  clear the buffer, single-cycle pulse
- rd_index  in  AW  evaluator read address
- rd_data  out  8  token at rd_index (combinational)
- length  out  AW  tokens stored, excluding '#'
- done  out  1  expression terminated; buffer locked
- err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async) sets state EDIT, wr_ptr=0, last_cls=NONE, err=0. Outputs during reset: key_ready=1, done=0, length=0. Memory contents are not reset.
- States:
  - EDIT: key_ready=1.
  - DONE: key_ready=0, done=1.
- Token acceptance is key_valid & key_ready, evaluated on the rising clk edge. The write takes effect at that edge, so length updates on the next cycle.
- Command priority in a single cycle: key_clear > key_back > key_valid. A lower-priority input is ignored that cycle.
- key_clear, from any state:
  - wr_ptr=0, last_cls=NONE, err=0, state=EDIT.
- key_back:
  - In EDIT with wr_ptr>0: wr_ptr decrements, and last_cls is recomputed from mem[wr_ptr-2] (NONE if wr_ptr was 1).
  - At wr_ptr=0 it is a no-op.
  - In DONE it is ignored.
- Accepted digit (0-9):
  - If wr_ptr < DEPTH-1: mem[wr_ptr]=code, wr_ptr+1, last_cls=DIGIT.
  - Otherwise the token is dropped and err=1 (overflow).
- Accepted operator (20-23):
  - Legal only when last_cls=DIGIT; then it is written like a digit and last_cls=OP.
  - If last_cls is NONE or OP: dropped, err=1.
  - Overflow is handled as for digits.
- Accepted '#' (10):
  - Legal only when last_cls=DIGIT.
  - mem[wr_ptr]=10, wr_ptr unchanged, state=DONE.
  - Otherwise dropped and err=1; state stays EDIT.
- Any other code is dropped and sets err=1.
- err is sticky; only key_clear or reset clears it. An error never changes wr_ptr or state.
- Read port is combinational, zero latency:
  - rd_data = mem[rd_index] when rd_index < wr_ptr, or when rd_index == wr_ptr and state=DONE.
  - Otherwise rd_data = 8'd10, so the evaluator always hits a terminator.
  - rd_index >= DEPTH returns 8'd10.
- length = wr_ptr. done = (state==DONE).

Test Plan:
1. Reset, then enter 1,5,22,1,0,10, one per cycle → done=1, length=5, err=0. rd_index 0..5 reads 1,5,22,1,0,10; rd_index 6 reads 10.
2. Empty buffer, send 20 → err=1, length=0. Then send 3 → length=1, err stays 1. Then key_clear → err=0, length=0, rd_data(0)=10.
3. Enter 7,21 then send 22 → second operator dropped, err=1, length=2. Then key_back → length=1, and a subsequent 22 is accepted (last_cls back to DIGIT).
4. Fill with DEPTH-1=99 digits, then send one more digit → length=99, err=1. Then send 10 → done=1, rd_data(99)=10.
5. In DONE, send key_valid with 4 → key_ready=0, nothing is written, length unchanged. key_back in DONE → no effect. Assert key_clear and key_valid(4) in the same cycle → clear wins, length=0, state EDIT.
6. Assert rst low mid-entry (after 3 tokens), asynchronously between clock edges → outputs reset immediately: length=0, done=0, err=0, key_ready=1. Release rst and enter 9,10 → length=1, rd_data(0)=9.
